regsrx8_axil_regs: RTL and testbench
====================================

# regsrx8_axil_regs

- AXI4-Lite slave register file for the RegSRx8 IP.
- Sits directly downstream of the AXI4-Lite master (the BFM in simulation, the PS interconnect in hardware) and is the endpoint of its single-beat writes and reads.
- Exposes four 32-bit registers at offsets 0x0–0xC.
- Writes to the data register push words into an 8-stage, 32-bit shift chain, whose stages are driven out to the fabric and are readable through a tap register.

## Interface

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; bits [3:2] select the register.
- SR_DEPTH, 8: number of shift-chain stages.

Ports (clock and reset first):
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S00_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S00_AXI_AWPROT  in  3  ignored.
- S00_AXI_AWVALID / S00_AXI_AWREADY  in / out  1  write address handshake.
- S00_AXI_WDATA  in  32  write data.
- S00_AXI_WSTRB  in  4  byte strobes.
- S00_AXI_WVALID / S00_AXI_WREADY  in / out  1  write data handshake.
- S00_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S00_AXI_BVALID / S00_AXI_BREADY  out / in  1  write response handshake.
- S00_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S00_AXI_ARPROT  in  3  ignored.
- S00_AXI_ARVALID / S00_AXI_ARREADY  in / out  1  read address handshake.
- S00_AXI_RDATA  out  32  read data.
- S00_AXI_RRESP  out  2  always 2'b00.
- S00_AXI_RVALID / S00_AXI_RREADY  out / in  1  read data handshake.
- sr_out  out  SR_DEPTH*32  stage k on bits [32k+31:32k]; stage 0 is the newest word.
- sr_en  out  1  mirror of CTRL[0].

## Operation

Register map:
- 0x0 CTRL, RW.
  - bit0 EN.
  - bit1 CLR: write-1 pulse that zeroes the chain. It always reads 0 and is not stored.
  - Bits [31:2] are stored and read back.
- 0x4 DIN, RW.
  - Strobe-merged into the stored value.
  - If EN=1 at commit time, the chain also shifts: stage0 <= merged value, stage k <= stage k-1, and the oldest stage is discarded.
  - If EN=0, only DIN updates.
- 0x8 TAPSEL, RW, bits [2:0] significant; upper bits are stored.
- 0xC TAP, RO. Reads the chain stage indexed by TAPSEL[2:0]. Writes are accepted with OKAY and have no effect.

Strobe and write rules:
- WSTRB applies per byte to CTRL, DIN and TAPSEL.
- A write with WSTRB=0 changes nothing but still receives a response; it does not shift the chain.
- CLR and shift in the same commit cannot occur, because they target different addresses.

Write channel:
- AW and W are accepted independently and each is held in a capture register.
- The commit happens on the edge where both are present, whether held or handshaking on that edge.
- BVALID rises on that same edge and stays high until BREADY.
- While BVALID=1, AWREADY=0 and WREADY=0.

Read channel:
- ARREADY = !RVALID.
- On an AR handshake, RDATA is registered from current state (pre-edge values) and RVALID=1 on the next cycle; it is held until RREADY.

## Timing

Reset:
- While ARESET=1, all registers, chain stages, capture flags, BVALID, RVALID and RDATA are 0.
- AWREADY, WREADY and ARREADY are registered: 0 during reset and 1 from the first edge after release.

Write latency:
- AW and W handshake at edge N: the register updates and BVALID=1 after edge N.
- Minimum 2 cycles per write with BREADY tied high (one cycle ready, one cycle response).

Read latency:
- AR handshake at edge N: RVALID=1 after edge N.
- Back-to-back reads every 2 cycles with RREADY held high.

Ordering and boundary cases:
- AW before W, or W before AW: the first channel is held and its READY drops until the commit.
- A read and a write committing on the same edge: the read returns pre-write data, e.g. TAP returns the pre-shift stage.
- Reset asserted mid-transaction: all state is cleared immediately, pending captures are dropped, and no B or R response is issued.
- The chain saturates nothing. Stage 7 simply falls off after 8 or more pushes.

## Structure

- Package regsrx8_pkg:
  - Register offset constants (ADDR_CTRL=2'd0, ADDR_DIN=2'd1, ADDR_TAPSEL=2'd2, ADDR_TAP=2'd3).
  - RESP_OKAY.
  - SR_DEPTH default.
  - CTRL bit indices.
- Sub-module regsrx8_shift_chain:
  - Parameterised width and depth.
  - Inputs: shift, din, clr, tapsel.
  - Outputs: flat stages and tap.
  - Same clock and reset as the top.

## Test plan

- Reset release: all READYs go 1 one edge after release; reading 0x0–0xC returns 0x00000000, and sr_out=0.
- Write CTRL=0x1, then DIN=0x11, 0x22, …, 0x88 (8 writes): sr_out stage0=0x88 … stage7=0x11. With TAPSEL=7, a read of 0xC returns 0x00000011.
- EN=0, write DIN=0xDEADBEEF: a read of 0x4 returns 0xDEADBEEF and sr_out is unchanged. Write CTRL=0x3: the chain is all zero and a read of 0x0 returns 0x1.
- WSTRB=4'b0010, write 0xAABBCCDD to TAPSEL (previously 0): a read of 0x8 returns 0x0000CC00.
- AW presented 3 cycles before W, with BREADY held low for 4 cycles: AWREADY drops after capture, one commit happens, BVALID stays high until BREADY, and BRESP=0.
- Same-edge AR to 0xC (TAPSEL=0) and a shifting DIN write of 0x99 while stage0=0x88: RDATA=0x88, and a subsequent read returns 0x99.

Source files
------------

// File: rtl/regsrx8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regsrx8_pkg
// Description : Shared constants and helpers for the RegSRx8 AXI4-Lite
//               register file: register offsets, response code, CTRL bit
//               positions and the byte-strobe merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package regsrx8_pkg;

  // Word offsets (byte address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIN    = 2'd1;
  localparam logic [1:0] ADDR_TAPSEL = 2'd2;
  localparam logic [1:0] ADDR_TAP    = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int SR_DEPTH_DEFAULT = 8;

  // CTRL bit positions
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // CLR is a pulse and never held in the CTRL register
  localparam logic [31:0] CTRL_STORE_MASK = 32'hFFFF_FFFD;

  // Replace each byte of old_val whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regsrx8_shift_chain.sv
`default_nettype none
// ============================================================================
// Module      : regsrx8_shift_chain
// Description : DEPTH-stage, WIDTH-bit shift chain. Stage 0 takes the new
//               word on a shift; the oldest stage falls off. A clear zeroes
//               every stage. Stages are exported flat plus a selected tap.
// Revision    : 1.0 - initial release
// ============================================================================
module regsrx8_shift_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAP_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_shift,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_clr,
  input  logic [TAP_W-1:0]         i_tapsel,
  output logic [DEPTH*WIDTH-1:0]   o_stages,
  output logic [WIDTH-1:0]         o_tap
);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [WIDTH-1:0] w_tap;

  // Chain storage: clear has priority, otherwise shift the new word in at stage 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
    end else if (i_shift) begin
      r_stage[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign o_stages[g*WIDTH +: WIDTH] = r_stage[g];
    end
  endgenerate

  // Tap multiplexer over the stages
  always_comb begin
    w_tap = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_tapsel == k[TAP_W-1:0]) w_tap = r_stage[k];
    end
  end

  assign o_tap = w_tap;

endmodule
`default_nettype wire

// File: rtl/regsrx8_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : regsrx8_axil_regs
// Description : AXI4-Lite slave with four 32-bit registers (CTRL, DIN,
//               TAPSEL, TAP). Writes to DIN with EN set push the merged word
//               into an SR_DEPTH-stage shift chain driven out on sr_out.
// Revision    : 1.0 - initial release
// ============================================================================
module regsrx8_axil_regs
  import regsrx8_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int SR_DEPTH           = SR_DEPTH_DEFAULT
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_AWADDR,
  input  logic [2:0]                      S00_AXI_AWPROT,
  input  logic                            S00_AXI_AWVALID,
  output logic                            S00_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S00_AXI_WSTRB,
  input  logic                            S00_AXI_WVALID,
  output logic                            S00_AXI_WREADY,
  output logic [1:0]                      S00_AXI_BRESP,
  output logic                            S00_AXI_BVALID,
  input  logic                            S00_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S00_AXI_ARADDR,
  input  logic [2:0]                      S00_AXI_ARPROT,
  input  logic                            S00_AXI_ARVALID,
  output logic                            S00_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S00_AXI_RDATA,
  output logic [1:0]                      S00_AXI_RRESP,
  output logic                            S00_AXI_RVALID,
  input  logic                            S00_AXI_RREADY,
  output logic [SR_DEPTH*32-1:0]          sr_out,
  output logic                            sr_en
);

  localparam int TAP_W = (SR_DEPTH > 1) ? $clog2(SR_DEPTH) : 1;

  // Write channel state
  logic        r_awready, r_wready, r_bvalid;
  logic        r_aw_held, r_w_held;
  logic [1:0]  r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Read channel state
  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;

  // Registers
  logic [31:0] r_ctrl, r_din, r_tapsel;

  logic        w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit;
  logic        w_bvalid_nxt, w_aw_held_nxt, w_w_held_nxt;
  logic [1:0]  w_waddr;
  logic [31:0] w_wdata_m, w_merged;
  logic [3:0]  w_wstrb_m;
  logic        w_shift, w_clr;
  logic        w_ar_hs, w_rvalid_nxt;
  logic [31:0] w_tap, w_rd_mux;
  logic        w_unused_ok;

  assign w_aw_hs   = S00_AXI_AWVALID & r_awready;
  assign w_w_hs    = S00_AXI_WVALID  & r_wready;
  assign w_aw_have = r_aw_held | w_aw_hs;
  assign w_w_have  = r_w_held  | w_w_hs;
  assign w_commit  = w_aw_have & w_w_have;

  // A held capture wins over the live bus, since its READY is already low
  assign w_waddr   = r_aw_held ? r_awaddr : S00_AXI_AWADDR[3:2];
  assign w_wdata_m = r_w_held  ? r_wdata  : S00_AXI_WDATA;
  assign w_wstrb_m = r_w_held  ? r_wstrb  : S00_AXI_WSTRB;

  assign w_bvalid_nxt  = w_commit | (r_bvalid & ~S00_AXI_BREADY);
  assign w_aw_held_nxt = w_aw_have & ~w_commit;
  assign w_w_held_nxt  = w_w_have  & ~w_commit;

  assign w_merged = apply_wstrb(r_din, w_wdata_m, w_wstrb_m);
  assign w_shift  = w_commit & (w_waddr == ADDR_DIN) & (|w_wstrb_m) & r_ctrl[CTRL_EN_BIT];
  assign w_clr    = w_commit & (w_waddr == ADDR_CTRL) & w_wstrb_m[0] & w_wdata_m[CTRL_CLR_BIT];

  assign w_ar_hs      = S00_AXI_ARVALID & r_arready;
  assign w_rvalid_nxt = w_ar_hs | (r_rvalid & ~S00_AXI_RREADY);

  assign w_unused_ok = ^{S00_AXI_AWPROT, S00_AXI_ARPROT, S00_AXI_AWADDR, S00_AXI_ARADDR};

  // Write-channel handshake: capture AW/W independently, commit when both present
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_bvalid  <= w_bvalid_nxt;
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) r_awaddr <= S00_AXI_AWADDR[3:2];
      if (w_w_hs) begin
        r_wdata <= S00_AXI_WDATA;
        r_wstrb <= S00_AXI_WSTRB;
      end
      r_awready <= ~w_bvalid_nxt & ~w_aw_held_nxt;
      r_wready  <= ~w_bvalid_nxt & ~w_w_held_nxt;
    end
  end

  // Register updates on commit; TAP is read-only so writes to it are dropped
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ctrl   <= '0;
      r_din    <= '0;
      r_tapsel <= '0;
    end else if (w_commit) begin
      case (w_waddr)
        ADDR_CTRL:   r_ctrl   <= apply_wstrb(r_ctrl, w_wdata_m, w_wstrb_m) & CTRL_STORE_MASK;
        ADDR_DIN:    r_din    <= w_merged;
        ADDR_TAPSEL: r_tapsel <= apply_wstrb(r_tapsel, w_wdata_m, w_wstrb_m);
        default:     ;
      endcase
    end
  end

  regsrx8_shift_chain #(
    .WIDTH (32),
    .DEPTH (SR_DEPTH),
    .TAP_W (TAP_W)
  ) u_chain (
    .clk      (ACLK),
    .rst      (ARESET),
    .i_shift  (w_shift),
    .i_din    (w_merged),
    .i_clr    (w_clr),
    .i_tapsel (r_tapsel[TAP_W-1:0]),
    .o_stages (sr_out),
    .o_tap    (w_tap)
  );

  // Read data selection from pre-edge register state
  always_comb begin
    w_rd_mux = '0;
    case (S00_AXI_ARADDR[3:2])
      ADDR_CTRL:   w_rd_mux = r_ctrl;
      ADDR_DIN:    w_rd_mux = r_din;
      ADDR_TAPSEL: w_rd_mux = r_tapsel;
      ADDR_TAP:    w_rd_mux = w_tap;
      default:     w_rd_mux = '0;
    endcase
  end

  // Read channel: one outstanding read, ARREADY low while RVALID is high
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_ar_hs) r_rdata <= w_rd_mux;
    end
  end

  assign S00_AXI_AWREADY = r_awready;
  assign S00_AXI_WREADY  = r_wready;
  assign S00_AXI_BVALID  = r_bvalid;
  assign S00_AXI_BRESP   = RESP_OKAY;
  assign S00_AXI_ARREADY = r_arready;
  assign S00_AXI_RVALID  = r_rvalid;
  assign S00_AXI_RDATA   = r_rdata;
  assign S00_AXI_RRESP   = RESP_OKAY;
  assign sr_en           = r_ctrl[CTRL_EN_BIT];

endmodule
`default_nettype wire

// File: tb/tb_regsrx8_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_regsrx8_axil_regs
// Description : Directed, table-driven self-checking bench for the RegSRx8
//               AXI4-Lite register file and shift chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regsrx8_axil_regs;

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_S = 2;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [3:0]   AWADDR = '0;
  logic [2:0]   AWPROT = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b1;
  logic [3:0]   ARADDR = '0;
  logic [2:0]   ARPROT = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b1;
  logic [255:0] sr_out;
  logic         sr_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  always #5 ACLK = ~ACLK;

  regsrx8_axil_regs dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .S00_AXI_AWADDR  (AWADDR),
    .S00_AXI_AWPROT  (AWPROT),
    .S00_AXI_AWVALID (AWVALID),
    .S00_AXI_AWREADY (AWREADY),
    .S00_AXI_WDATA   (WDATA),
    .S00_AXI_WSTRB   (WSTRB),
    .S00_AXI_WVALID  (WVALID),
    .S00_AXI_WREADY  (WREADY),
    .S00_AXI_BRESP   (BRESP),
    .S00_AXI_BVALID  (BVALID),
    .S00_AXI_BREADY  (BREADY),
    .S00_AXI_ARADDR  (ARADDR),
    .S00_AXI_ARPROT  (ARPROT),
    .S00_AXI_ARVALID (ARVALID),
    .S00_AXI_ARREADY (ARREADY),
    .S00_AXI_RDATA   (RDATA),
    .S00_AXI_RRESP   (RRESP),
    .S00_AXI_RVALID  (RVALID),
    .S00_AXI_RREADY  (RREADY),
    .sr_out          (sr_out),
    .sr_en           (sr_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stage(input int k);
    return sr_out[32*k +: 32];
  endfunction

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n;
    logic ag, wg;
    @(negedge ACLK);
    AWADDR = a; AWVALID = 1'b1;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      ag = AWVALID && AWREADY;
      wg = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (ag) AWVALID = 1'b0;
      if (wg) WVALID = 1'b0;
      if (AWVALID || WVALID) @(negedge ACLK);
      n++;
    end
    if (AWVALID || WVALID) begin
      checks++; errors++;
      $display("FAIL wr_handshake_timeout actual=pending required=accepted");
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    n = 0;
    while (!BVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL wr_bvalid_timeout actual=0 required=1");
    end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int   n;
    logic go;
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1;
    n = 0;
    while (ARVALID && n < 20) begin
      go = ARREADY;
      @(posedge ACLK); #1;
      if (go) ARVALID = 1'b0;
      else @(negedge ACLK);
      n++;
    end
    if (ARVALID) begin
      checks++; errors++;
      $display("FAIL rd_handshake_timeout actual=pending required=accepted");
      ARVALID = 1'b0;
    end
    n = 0;
    while (!RVALID && n < 20) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (!RVALID) begin
      checks++; errors++;
      $display("FAIL rd_rvalid_timeout actual=0 required=1");
    end
    d = RDATA;
    @(posedge ACLK); #1;
  endtask

  task automatic addv(input int op, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.strb = s; v.exp = e;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;

    // ---------------- vector table ----------------
    addv(OP_R, 4'h0, 0, 0, 32'h0);
    addv(OP_R, 4'h4, 0, 0, 32'h0);
    addv(OP_R, 4'h8, 0, 0, 32'h0);
    addv(OP_R, 4'hC, 0, 0, 32'h0);
    addv(OP_W, 4'h0, 32'h1, 4'hF, 0);
    for (int i = 1; i <= 8; i++) addv(OP_W, 4'h4, 32'h11 * i, 4'hF, 0);
    addv(OP_S, 4'd0, 0, 0, 32'h88);
    addv(OP_S, 4'd3, 0, 0, 32'h55);
    addv(OP_S, 4'd7, 0, 0, 32'h11);
    addv(OP_W, 4'h8, 32'h7, 4'hF, 0);
    addv(OP_R, 4'hC, 0, 0, 32'h11);
    addv(OP_R, 4'h0, 0, 0, 32'h1);
    addv(OP_W, 4'h0, 32'h0, 4'hF, 0);
    addv(OP_W, 4'h4, 32'hDEADBEEF, 4'hF, 0);
    addv(OP_R, 4'h4, 0, 0, 32'hDEADBEEF);
    addv(OP_S, 4'd0, 0, 0, 32'h88);
    addv(OP_W, 4'h0, 32'h3, 4'hF, 0);
    addv(OP_S, 4'd0, 0, 0, 32'h0);
    addv(OP_S, 4'd7, 0, 0, 32'h0);
    addv(OP_R, 4'h0, 0, 0, 32'h1);
    addv(OP_W, 4'h8, 32'h0, 4'hF, 0);
    addv(OP_W, 4'h8, 32'hAABBCCDD, 4'b0010, 0);
    addv(OP_R, 4'h8, 0, 0, 32'h0000CC00);
    addv(OP_W, 4'h8, 32'h0, 4'hF, 0);
    addv(OP_W, 4'h4, 32'h55, 4'h0, 0);
    addv(OP_S, 4'd0, 0, 0, 32'h0);
    addv(OP_R, 4'h4, 0, 0, 32'hDEADBEEF);
    addv(OP_W, 4'h0, 32'hFFFFFFFF, 4'hF, 0);
    addv(OP_R, 4'h0, 0, 0, 32'hFFFFFFFD);
    addv(OP_W, 4'h0, 32'h1, 4'hF, 0);
    addv(OP_W, 4'hC, 32'h12345678, 4'hF, 0);
    addv(OP_R, 4'h8, 0, 0, 32'h0);
    addv(OP_R, 4'hC, 0, 0, 32'h0);
    addv(OP_W, 4'h4, 32'hA5, 4'b0001, 0);
    addv(OP_S, 4'd0, 0, 0, 32'hDEADBEA5);
    addv(OP_R, 4'h4, 0, 0, 32'hDEADBEA5);

    // ---------------- reset state ----------------
    repeat (3) @(negedge ACLK);
    check("rst_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h0);
    check("rst_valids",  {30'b0, BVALID, RVALID}, 32'h0);
    check("rst_rdata",   RDATA, 32'h0);
    check("rst_sr_out",  {31'b0, |sr_out}, 32'h0);
    check("rst_sr_en",   {31'b0, sr_en}, 32'h0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("rel_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);

    // ---------------- table ----------------
    for (int i = 0; i < vq.size(); i++) begin
      case (vq[i].op)
        OP_W: axi_write(vq[i].addr, vq[i].data, vq[i].strb);
        OP_R: begin
          axi_read(vq[i].addr, rd);
          check($sformatf("vec%0d_read", i), rd, vq[i].exp);
        end
        default: check($sformatf("vec%0d_stage%0d", i, vq[i].addr),
                       stage(int'(vq[i].addr)), vq[i].exp);
      endcase
    end
    check("sr_en_on", {31'b0, sr_en}, 32'h1);

    // ---------------- AW three cycles ahead of W, BREADY held low ----------------
    @(negedge ACLK);
    AWADDR = 4'h4; AWVALID = 1'b1; BREADY = 1'b0;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("awfirst_ready_after_cap", {30'b0, AWREADY, WREADY}, 32'h1);
    repeat (2) @(posedge ACLK);
    #1;
    check("awfirst_no_early_b", {31'b0, BVALID}, 32'h0);
    @(negedge ACLK);
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    check("awfirst_bvalid", {31'b0, BVALID}, 32'h1);
    check("awfirst_bresp", {30'b0, BRESP}, 32'h0);
    check("awfirst_readies_low", {30'b0, AWREADY, WREADY}, 32'h0);
    repeat (4) @(posedge ACLK);
    #1;
    check("awfirst_bvalid_held", {31'b0, BVALID}, 32'h1);
    @(negedge ACLK);
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    check("awfirst_bvalid_done", {31'b0, BVALID}, 32'h0);
    check("awfirst_readies_back", {30'b0, AWREADY, WREADY}, 32'h3);
    check("awfirst_stage0", stage(0), 32'h77);
    check("awfirst_stage1", stage(1), 32'hDEADBEA5);
    check("awfirst_stage2", stage(2), 32'h0);

    // ---------------- same-edge read of TAP and shifting write ----------------
    axi_write(4'h4, 32'h88, 4'hF);
    @(negedge ACLK);
    ARADDR = 4'hC; ARVALID = 1'b1;
    AWADDR = 4'h4; AWVALID = 1'b1;
    WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    check("same_edge_rvalid", {31'b0, RVALID}, 32'h1);
    check("same_edge_rdata", RDATA, 32'h88);
    check("same_edge_bvalid", {31'b0, BVALID}, 32'h1);
    @(posedge ACLK); #1;
    axi_read(4'hC, rd);
    check("same_edge_after", rd, 32'h99);
    check("same_edge_stage1", stage(1), 32'h88);

    // ---------------- reset in the middle of transactions ----------------
    @(negedge ACLK);
    AWADDR = 4'h4; AWVALID = 1'b1;
    ARADDR = 4'h0; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; ARVALID = 1'b0;
    check("mid_rvalid_pending", {31'b0, RVALID}, 32'h1);
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check("mid_rst_valids", {30'b0, BVALID, RVALID}, 32'h0);
    check("mid_rst_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h0);
    check("mid_rst_sr_out", {31'b0, |sr_out}, 32'h0);
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0; RREADY = 1'b1;
    @(posedge ACLK); #1;
    check("mid_rel_readies", {29'b0, AWREADY, WREADY, ARREADY}, 32'h7);
    @(negedge ACLK);
    WDATA = 32'h42; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("mid_aw_dropped", {31'b0, BVALID}, 32'h0);
    @(negedge ACLK);
    AWADDR = 4'h8; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    check("mid_late_aw_bvalid", {31'b0, BVALID}, 32'h1);
    @(posedge ACLK); #1;
    axi_read(4'h8, rd);
    check("mid_tapsel_written", rd, 32'h42);
    axi_read(4'h4, rd);
    check("mid_din_cleared", rd, 32'h0);
    axi_read(4'h0, rd);
    check("mid_ctrl_cleared", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
